// File: rtl/universal_reg.sv
// Universal shift/rotate/load register with optional up/down counting and terminal-count flag.
// Counting modes (6/7) and the tc register exist only when UREG_COUNT_EN is defined.
module universal_reg #(
  parameter int unsigned      WIDTH      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             preset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero,
  output logic             tc
);

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_LOAD = 3'd1,
    M_SHL  = 3'd2,
    M_SHR  = 3'd3,
    M_ROL  = 3'd4,
    M_ROR  = 3'd5,
    M_INC  = 3'd6,
    M_DEC  = 3'd7
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_tc_next;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);

  always_comb begin
    w_next    = r_q;
    w_tc_next = 1'b0;
    unique case (w_mode)
      M_HOLD: w_next = r_q;
      M_LOAD: w_next = d;
      M_SHL:  w_next = {r_q[WIDTH-2:0], sin_l};
      M_SHR:  w_next = {sin_r, r_q[WIDTH-1:1]};
      M_ROL:  w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      M_ROR:  w_next = {r_q[0], r_q[WIDTH-1:1]};
`ifdef UREG_COUNT_EN
      M_INC: begin
        w_next    = r_q + {{(WIDTH-1){1'b0}}, 1'b1};
        w_tc_next = (r_q == '1);
      end
      M_DEC: begin
        w_next    = r_q - {{(WIDTH-1){1'b0}}, 1'b1};
        w_tc_next = (r_q == '0);
      end
`else
      M_INC, M_DEC: w_next = r_q;
`endif
      default: w_next = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q <= RESET_VAL;
    end else if (preset) begin
      r_q <= PRESET_VAL;
    end else if (en) begin
      r_q <= w_next;
    end
  end

`ifdef UREG_COUNT_EN
  logic r_tc;

  // tc is a one-cycle pulse: preset and hold edges both clear it
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_tc <= 1'b0;
    end else if (preset || !en) begin
      r_tc <= 1'b0;
    end else begin
      r_tc <= w_tc_next;
    end
  end

  assign tc = r_tc;
`else
  logic w_unused_tc;
  assign w_unused_tc = w_tc_next;
  assign tc          = 1'b0;
`endif

  assign q      = r_q;
  assign qbar   = ~r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign zero   = (r_q == '0);

endmodule

// File: tb/tb_universal_reg.sv
// Directed self-checking bench for universal_reg (WIDTH=4, RESET_VAL=0, PRESET_VAL=F).
// Counting expectations follow UREG_COUNT_EN as seen by this compile.
`timescale 1ns/1ps
module tb_universal_reg;
  logic       clk;
  logic       clr_n;
  logic       preset;
  logic       en;
  logic [2:0] mode;
  logic [3:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [3:0] q;
  logic [3:0] qbar;
  logic       sout_l;
  logic       sout_r;
  logic       zero;
  logic       tc;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  universal_reg #(
    .WIDTH     (4),
    .RESET_VAL (4'h0),
    .PRESET_VAL(4'hF)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .preset(preset),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .q     (q),
    .qbar  (qbar),
    .sout_l(sout_l),
    .sout_r(sout_r),
    .zero  (zero),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    en   = 1'b1;
    mode = 3'd1;
    d    = v;
    tick();
  endtask

  initial begin
    clr_n = 1'b0; preset = 1'b0; en = 1'b0; mode = 3'd0;
    d = 4'h0; sin_l = 1'b0; sin_r = 1'b0;
    #2;
    check("rst_q",    q,    4'h0);
    check("rst_qbar", qbar, 4'hF);
    check("rst_zero", zero, 1'b1);
    check("rst_tc",   tc,   1'b0);

    clr_n = 1'b1;
    load(4'hA);
    check("load_q",      q,      4'hA);
    check("load_qbar",   qbar,   4'h5);
    check("load_zero",   zero,   1'b0);
    check("load_sout_l", sout_l, 1'b1);
    check("load_sout_r", sout_r, 1'b0);

    load(4'h1);
    mode = 3'd2; sin_l = 1'b1;
    tick(); check("shl1", q, 4'h3);
    tick(); check("shl2", q, 4'h7);
    tick(); check("shl3", q, 4'hF);
    check("shl_tc", tc, 1'b0);
    mode = 3'd3; sin_r = 1'b0;
    tick(); check("shr1", q, 4'h7);
    check("shr1_sout_r", sout_r, 1'b1);
    check("shr1_sout_l", sout_l, 1'b0);
    tick(); check("shr2", q, 4'h3);

    load(4'h9);
    mode = 3'd4; sin_l = 1'b0; sin_r = 1'b1;
    tick(); check("rol", q, 4'h3);
    mode = 3'd5; sin_l = 1'b1; sin_r = 1'b0;
    tick(); check("ror", q, 4'h9);

`ifdef UREG_COUNT_EN
    load(4'hE);
    mode = 3'd6;
    tick(); check("inc1_q", q, 4'hF); check("inc1_tc", tc, 1'b0);
    tick(); check("inc2_q", q, 4'h0); check("inc2_tc", tc, 1'b1);
    mode = 3'd0;
    tick(); check("hold_q", q, 4'h0); check("hold_tc", tc, 1'b0);
    mode = 3'd7;
    tick(); check("dec_q", q, 4'hF); check("dec_tc", tc, 1'b1);
    tick(); check("dec2_q", q, 4'hE); check("dec2_tc", tc, 1'b0);
    load(4'hF);
    mode = 3'd6;
    tick(); check("wrap_tc", tc, 1'b1);
    en = 1'b0;
    tick(); check("en0_q", q, 4'h0); check("en0_tc", tc, 1'b0);
`else
    load(4'h5);
    mode = 3'd6;
    tick(); check("noinc_q", q, 4'h5); check("noinc_tc", tc, 1'b0);
    mode = 3'd7;
    tick(); check("nodec_q", q, 4'h5); check("nodec_tc", tc, 1'b0);
`endif

    load(4'h5);
    en = 1'b0; preset = 1'b1; mode = 3'd1; d = 4'h0;
    tick(); check("preset_q", q, 4'hF); check("preset_tc", tc, 1'b0);
    preset = 1'b0; en = 1'b0; mode = 3'd6;
    tick(); check("en0_hold", q, 4'hF);

    en = 1'b1; mode = 3'd6;
    clr_n = 1'b0;
    #1;
    check("async_q",    q,    4'h0);
    check("async_qbar", qbar, 4'hF);
    check("async_tc",   tc,   1'b0);
    preset = 1'b1;
    tick(); check("rst_hold_q", q, 4'h0); check("rst_hold_tc", tc, 1'b0);
    tick(); check("rst_hold2_q", q, 4'h0);
    preset = 1'b0;
    #2;
    clr_n = 1'b1; mode = 3'd1; d = 4'h3;
    tick(); check("resume_q", q, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
